membrane_potential_store: RTL and testbench

//   Per-neuron membrane-potential register file at the writeback end of the neuron datapath.

---
 rtl/membrane_potential_store_pkg.sv | 14 +
 rtl/membrane_potential_store_spike_counter.sv | 34 +++
 rtl/membrane_potential_store.sv | 116 +++++++++++
 tb/tb_membrane_potential_store.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/membrane_potential_store_pkg.sv
// Shared constants for the membrane-potential store: FSM encoding, FP bit patterns and
// default array geometry.
package membrane_potential_store_pkg;

  localparam int DEFAULT_NUM_NEURONS = 32;
  localparam int DEFAULT_ADDR_W      = $clog2(DEFAULT_NUM_NEURONS);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/membrane_potential_store_spike_counter.sv
// Registers spike events and keeps a saturating spike count for the current timestep.
module spike_event_counter #(
  parameter int ID_W  = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             event_valid,
  input  logic [ID_W-1:0]  event_id,
  input  logic             count_clear,
  output logic             spike_valid,
  output logic [ID_W-1:0]  spike_id,
  output logic [CNT_W-1:0] spike_count
);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_valid <= 1'b0;
      spike_id    <= '0;
      spike_count <= '0;
    end else begin
      spike_valid <= event_valid;
      if (event_valid) spike_id <= event_id;
      // A new timestep wins over a spike landing on the same edge.
      if (count_clear)
        spike_count <= '0;
      else if (event_valid && (spike_count != '1))
        spike_count <= spike_count + 1'b1;
    end
  end

endmodule

// File: rtl/membrane_potential_store.sv
// Per-neuron membrane-potential register file with registered reads, spike event output
// and a one-entry-per-cycle clear sweep at the start of every timestep.
module membrane_potential_store
  import membrane_potential_store_pkg::*;
#(
  parameter int                NUM_NEURONS = DEFAULT_NUM_NEURONS,
  parameter int                ADDR_W      = DEFAULT_ADDR_W,
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] INIT_VALUE  = FP_ZERO,
  parameter int                CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              clear_busy,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_spiked,
  output logic              ready,
  output logic              spike_valid,
  output logic [ADDR_W-1:0] spike_id,
  output logic [CNT_W-1:0]  spike_count,
  output logic              addr_err
);

  localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W+1)'(NUM_NEURONS);
  localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(NUM_NEURONS - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [NUM_NEURONS];

  logic rd_acc, wr_acc, rd_in_range, wr_in_range, wr_commit, clear_start;

  assign clear_busy  = (state == ST_CLEAR);
  assign ready       = ~clear_busy;
  assign rd_acc      = rd_en & ready;
  assign wr_acc      = wr_en & ready;
  assign rd_in_range = ({1'b0, rd_addr} < ADDR_LIMIT);
  assign wr_in_range = ({1'b0, wr_addr} < ADDR_LIMIT);
  assign wr_commit   = wr_acc & wr_in_range;
  assign clear_start = (state == ST_IDLE) & clear_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      clr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
          end
        end
        default: begin
          // clear_req is deliberately not looked at here: a sweep never restarts.
          if (clr_ptr == LAST_PTR) state <= ST_IDLE;
          else                     clr_ptr <= clr_ptr + 1'b1;
        end
      endcase
    end
  end

  // NOTE: the potential array is built from resettable flops rather than a RAM macro,
  // because reset must put every entry back to the resting potential asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) mem[i] <= INIT_VALUE;
    end else if (clear_busy) begin
      mem[clr_ptr] <= INIT_VALUE;
    end else if (wr_commit) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      addr_err <= (rd_acc & ~rd_in_range) | (wr_acc & ~wr_in_range);
      // Write-first: a read colliding with this cycle's write sees the new potential.
      if (rd_acc) begin
        if (!rd_in_range)
          rd_data <= INIT_VALUE;
        else if (wr_commit && (wr_addr == rd_addr))
          rd_data <= wr_data;
        else
          rd_data <= mem[rd_addr];
      end
    end
  end

  spike_event_counter #(
    .ID_W  (ADDR_W),
    .CNT_W (CNT_W)
  ) u_spike_counter (
    .clk         (clk),
    .rst         (rst),
    .event_valid (wr_commit & wr_spiked),
    .event_id    (wr_addr),
    .count_clear (clear_start),
    .spike_valid (spike_valid),
    .spike_id    (spike_id),
    .spike_count (spike_count)
  );

endmodule

// File: tb/tb_membrane_potential_store.sv
// Directed bench for membrane_potential_store: a 32-entry instance plus a 20-entry instance
// sharing the same stimulus, the latter used for out-of-range accesses.
module tb_membrane_potential_store;
  import membrane_potential_store_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_req = 1'b0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_spiked = 1'b0;

  logic        clear_busy, rd_valid, ready, spike_valid, addr_err;
  logic [31:0] rd_data;
  logic [4:0]  spike_id;
  logic [7:0]  spike_count;

  logic        clear_busy20, rd_valid20, ready20, spike_valid20, addr_err20;
  logic [31:0] rd_data20;
  logic [4:0]  spike_id20;
  logic [7:0]  spike_count20;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  membrane_potential_store dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .clear_busy(clear_busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_spiked(wr_spiked),
    .ready(ready), .spike_valid(spike_valid), .spike_id(spike_id),
    .spike_count(spike_count), .addr_err(addr_err)
  );

  membrane_potential_store #(.NUM_NEURONS(20), .ADDR_W(5)) dut20 (
    .clk(clk), .rst(rst), .clear_req(clear_req), .clear_busy(clear_busy20),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid20), .rd_data(rd_data20),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_spiked(wr_spiked),
    .ready(ready20), .spike_valid(spike_valid20), .spike_id(spike_id20),
    .spike_count(spike_count20), .addr_err(addr_err20)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++;
    if (clear_busy !== 1'b0 || rd_valid !== 1'b0 || spike_valid !== 1'b0 || addr_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b rd_valid=%b spike_valid=%b addr_err=%b expected all 0",
               clear_busy, rd_valid, spike_valid, addr_err);
    end
    checks++;
    if (rd_data !== 32'h0 || spike_count !== 8'd0 || spike_id !== 5'd0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values rd_data=%h count=%0d id=%0d ready=%b expected 0/0/0/1",
               rd_data, spike_count, spike_id, ready);
    end
    tick();
    rst = 1'b0;
    tick();
    rd_en = 1'b1; rd_addr = 5'd3;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h0000_0000 || spike_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_read3 rd_valid=%b rd_data=%h count=%0d expected 1/00000000/0",
               rd_valid, rd_data, spike_count);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_valid_pulse got %b expected 0", rd_valid);
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = FP_ONE; wr_spiked = 1'b0;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 5'd5;
    checks++;
    if (spike_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_nospike spike_valid=%b expected 0", spike_valid);
    end
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h3F80_0000 || spike_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_read5 rd_valid=%b rd_data=%h spike_valid=%b expected 1/3f800000/0",
               rd_valid, rd_data, spike_valid);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h3F80_0000) begin
      errors++;
      $display("FAIL rd_data_hold rd_valid=%b rd_data=%h expected 0/3f800000", rd_valid, rd_data);
    end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h3F00_0000; wr_spiked = 1'b1;
    rd_en = 1'b1; rd_addr = 5'd7;
    tick();
    wr_en = 1'b0; rd_en = 1'b0; wr_spiked = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h3F00_0000) begin
      errors++;
      $display("FAIL bypass_data rd_valid=%b rd_data=%h expected 1/3f000000", rd_valid, rd_data);
    end
    checks++;
    if (spike_valid !== 1'b1 || spike_id !== 5'd7 || spike_count !== 8'd1) begin
      errors++;
      $display("FAIL bypass_spike valid=%b id=%0d count=%0d expected 1/7/1",
               spike_valid, spike_id, spike_count);
    end
    tick();
    checks++;
    if (spike_valid !== 1'b0 || spike_count !== 8'd1) begin
      errors++;
      $display("FAIL spike_pulse valid=%b count=%0d expected 0/1", spike_valid, spike_count);
    end
  endtask

  task automatic test_clear();
    int busy_cycles;
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'h4000_0000 | 32'(i); wr_spiked = i[0];
      tick();
    end
    wr_en = 1'b0; wr_spiked = 1'b0;
    rd_en = 1'b1; rd_addr = 5'd0;
    tick();
    rd_addr = 5'd31;
    checks++;
    if (rd_data !== 32'h4000_0000) begin
      errors++;
      $display("FAIL fill_read0 got %h expected 40000000", rd_data);
    end
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_data !== 32'h4000_001F) begin
      errors++;
      $display("FAIL fill_read31 got %h expected 4000001f", rd_data);
    end
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    checks++;
    if (spike_count !== 8'd0) begin
      errors++;
      $display("FAIL clear_count got %0d expected 0", spike_count);
    end
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD_BEEF; wr_spiked = 1'b1;
    rd_en = 1'b1; rd_addr = 5'd1;
    busy_cycles = 0;
    while (clear_busy === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      clear_req = (busy_cycles == 5);
      checks++;
      if (ready !== 1'b0 || rd_valid !== 1'b0 || spike_valid !== 1'b0 || addr_err !== 1'b0) begin
        errors++;
        $display("FAIL sweep_drop cycle=%0d ready=%b rd_valid=%b spike_valid=%b addr_err=%b expected 0/0/0/0",
                 busy_cycles, ready, rd_valid, spike_valid, addr_err);
      end
      tick();
    end
    wr_en = 1'b0; wr_spiked = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
    checks++;
    if (busy_cycles != 32) begin
      errors++;
      $display("FAIL clear_busy_len got %0d cycles expected 32", busy_cycles);
    end
    checks++;
    if (ready !== 1'b1 || spike_count !== 8'd0) begin
      errors++;
      $display("FAIL post_sweep ready=%b count=%0d expected 1/0", ready, spike_count);
    end
    rd_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
        errors++;
        $display("FAIL cleared_entry%0d rd_valid=%b rd_data=%h expected 1/00000000", i, rd_valid, rd_data);
      end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back_saturate();
    int expected;
    for (int n = 1; n <= 260; n++) begin
      wr_en = 1'b1; wr_addr = 5'(n % 32); wr_data = 32'(n); wr_spiked = 1'b1;
      tick();
      expected = (n > 255) ? 255 : n;
      checks++;
      if (spike_valid !== 1'b1 || spike_count !== 8'(expected)) begin
        errors++;
        $display("FAIL saturate n=%0d valid=%b count=%0d expected 1/%0d", n, spike_valid, spike_count, expected);
      end
    end
    wr_en = 1'b0; wr_spiked = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = FP_ONE; wr_spiked = 1'b0;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 5'd2;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_data !== FP_ONE) begin
      errors++;
      $display("FAIL pre_sweep_read2 got %h expected 3f800000", rd_data);
    end
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (9) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (clear_busy !== 1'b0 || ready !== 1'b1 || rd_data !== 32'h0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset busy=%b ready=%b rd_data=%h rd_valid=%b expected 0/1/00000000/0",
               clear_busy, ready, rd_data, rd_valid);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (clear_busy !== 1'b0 || clear_busy20 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle busy=%b busy20=%b expected 0/0", clear_busy, clear_busy20);
    end
    rd_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_entry%0d rd_valid=%b rd_data=%h expected 1/00000000", i, rd_valid, rd_data);
      end
    end
    rd_en = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = FP_ONE; wr_spiked = 1'b0;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 5'd4;
    tick();
    rd_addr = 5'd25;
    checks++;
    if (rd_data20 !== FP_ONE || addr_err20 !== 1'b0) begin
      errors++;
      $display("FAIL n20_read4 rd_data=%h addr_err=%b expected 3f800000/0", rd_data20, addr_err20);
    end
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_valid20 !== 1'b1 || rd_data20 !== 32'h0 || addr_err20 !== 1'b1) begin
      errors++;
      $display("FAIL n20_read25 rd_valid=%b rd_data=%h addr_err=%b expected 1/00000000/1",
               rd_valid20, rd_data20, addr_err20);
    end
    checks++;
    if (addr_err !== 1'b0) begin
      errors++;
      $display("FAIL n32_read25_addr_err got %b expected 0", addr_err);
    end
    wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'h4100_0000; wr_spiked = 1'b1;
    tick();
    wr_en = 1'b0; wr_spiked = 1'b0;
    checks++;
    if (addr_err20 !== 1'b1 || spike_valid20 !== 1'b0 || spike_count20 !== 8'd0) begin
      errors++;
      $display("FAIL n20_write25 addr_err=%b spike_valid=%b count=%0d expected 1/0/0",
               addr_err20, spike_valid20, spike_count20);
    end
    tick();
    checks++;
    if (addr_err20 !== 1'b0) begin
      errors++;
      $display("FAIL addr_err_pulse got %b expected 0", addr_err20);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_back_to_back_saturate();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
